// File: rtl/seg_scan_pkg.sv
// Shared constants for the six-digit multiplexed seven-segment scanner.
// Glyphs are 7-bit active-low {g,f,e,d,c,b,a}; dp is added by the parent.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 6;
  localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  // Digit slots that carry the hh.mm.ss separator dot.
  localparam logic [2:0] SEP_POS_A = 3'd1;
  localparam logic [2:0] SEP_POS_B = 3'd3;

  // Frame-stable copy of the time inputs.
  typedef struct packed {
    logic [1:0] hour_t;
    logic [3:0] hour_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
  } time_t;

endpackage

// File: rtl/seg_scan_6_decode.sv
// BCD to active-low seven-segment glyph; anything above 9 shows a dash.
module seg_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);

  // Pure lookup, no state.
  always_comb begin
    glyph = GLYPH_DASH;
    case (bcd)
      4'd0: glyph = GLYPH_0;
      4'd1: glyph = GLYPH_1;
      4'd2: glyph = GLYPH_2;
      4'd3: glyph = GLYPH_3;
      4'd4: glyph = GLYPH_4;
      4'd5: glyph = GLYPH_5;
      4'd6: glyph = GLYPH_6;
      4'd7: glyph = GLYPH_7;
      4'd8: glyph = GLYPH_8;
      4'd9: glyph = GLYPH_9;
      default: glyph = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_6.sv
// Six-digit hh.mm.ss scanner for a common-anode multiplexed display.
// Inputs are captured once per frame so a frame never mixes two times.
// Optional feature: define SEG_SCAN_BLINK_EN to blink the separator dots
// every BLINK_FRAMES frames.
module seg_scan_6
  import seg_scan_pkg::*;
#(
  parameter int T_SCAN       = 50_000,
  parameter int BLINK_FRAMES = 83
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hour_t,
  input  logic [3:0] hour_u,
  input  logic [2:0] min_t,
  input  logic [3:0] min_u,
  input  logic [2:0] sec_t,
  input  logic [3:0] sec_u,
  output logic [5:0] sel,
  output logic [7:0] seg,
  output logic       frame_done
);

  localparam int CW = (T_SCAN > 1) ? $clog2(T_SCAN) : 1;

  logic [CW-1:0] scan_cnt;
  logic          tick;
  logic [2:0]    idx;
  logic          running;   // low from reset until the first tick: display blank
  logic          wrap;      // tick on which idx goes 5 -> 0
  logic          wrap_q;    // delays frame_done onto the idx0 sel update
  time_t         shadow;
  logic [3:0]    digit;
  logic [6:0]    glyph;
  logic          sep_pos;
  logic          dp_lit;

  assign tick    = (scan_cnt == CW'(T_SCAN - 1));
  assign wrap    = tick && (idx == IDX_LAST);
  assign sep_pos = (idx == SEP_POS_A) || (idx == SEP_POS_B);

  // Free-running slot timer, 0..T_SCAN-1.
  always_ff @(posedge clk) begin
    if (rst)       scan_cnt <= '0;
    else if (tick) scan_cnt <= '0;
    else           scan_cnt <= scan_cnt + 1'b1;
  end

  // Digit index, frame-start capture of the inputs, display enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= IDX_LAST;
      running <= 1'b0;
      shadow  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= wrap;
      if (tick) begin
        running <= 1'b1;
        idx     <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end
      if (wrap) begin
        shadow <= '{hour_t: hour_t, hour_u: hour_u, min_t: min_t,
                    min_u: min_u, sec_t: sec_t, sec_u: sec_u};
      end
    end
  end

  // Pick the current digit from the frame-stable copy, leftmost first.
  always_comb begin
    digit = 4'hF;
    case (idx)
      3'd0: digit = {2'b00, shadow.hour_t};
      3'd1: digit = shadow.hour_u;
      3'd2: digit = {1'b0, shadow.min_t};
      3'd3: digit = shadow.min_u;
      3'd4: digit = {1'b0, shadow.sec_t};
      3'd5: digit = shadow.sec_u;
      default: digit = 4'hF;
    endcase
  end

  seg_decode u_decode (
    .bcd   (digit),
    .glyph (glyph)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] blink_cnt;
  logic          blink_phase;

  // Count completed frames; the capture tick that starts the scan is not one.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wrap && running) begin
      if (blink_cnt == FW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign dp_lit = sep_pos && blink_phase;
`else
  // Blink period has no effect in this build.
  logic unused_blink_frames;
  assign unused_blink_frames = ^BLINK_FRAMES;

  assign dp_lit = sep_pos;
`endif

  // Registered drive of the display pins, one clock behind idx/shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= 6'b111111;
      seg        <= {1'b1, GLYPH_BLANK};
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap_q;
      if (running) begin
        sel <= ~(6'b000001 << idx);
        seg <= {~dp_lit, glyph};
      end else begin
        sel <= 6'b111111;
        seg <= {1'b1, GLYPH_BLANK};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_6.sv
// Bench for seg_scan_6: one instance at T_SCAN=4 for the directed time
// sequence, one at T_SCAN=1 for the fastest scan rate.
module tb_seg_scan_6;

`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_b;
  logic [1:0] hour_t;
  logic [3:0] hour_u;
  logic [2:0] min_t;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic [5:0] sel, sel_b;
  logic [7:0] seg, seg_b;
  logic       frame_done, frame_done_b;

  seg_scan_6 #(.T_SCAN(4), .BLINK_FRAMES(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .hour_t     (hour_t),
    .hour_u     (hour_u),
    .min_t      (min_t),
    .min_u      (min_u),
    .sec_t      (sec_t),
    .sec_u      (sec_u),
    .sel        (sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  seg_scan_6 #(.T_SCAN(1), .BLINK_FRAMES(2)) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .hour_t     (hour_t),
    .hour_u     (hour_u),
    .min_t      (min_t),
    .min_u      (min_u),
    .sec_t      (sec_t),
    .sec_u      (sec_u),
    .sel        (sel_b),
    .seg        (seg_b),
    .frame_done (frame_done_b)
  );

  int cyc = 0;
  int rel = 0;
  always @(posedge clk) cyc++;

  // Scoreboard: entries are {sel, seg, frame_done}
  logic [14:0] exp_q[$];
  logic [14:0] exp_b_q[$];
  int frame_no   = 0;
  int frame_no_b = 0;
  int checks     = 0;
  int passed     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] glyph8(input logic [3:0] v);
    case (v)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  // Driver: queue the expected digit slots of one frame (digits hh mm ss).
  task automatic push_frame(input bit to_b, input logic [23:0] digs, input int nslots);
    logic       lit;
    logic [3:0] d;
    logic [7:0] sg;
    logic [5:0] sl;
    int         fn;
    fn  = to_b ? frame_no_b : frame_no;
    lit = !BLINK || (((fn / 2) % 2) == 0);
    for (int i = 0; i < nslots; i++) begin
      d  = digs[23 - 4*i -: 4];
      sg = glyph8(d);
      if ((i == 1 || i == 3) && lit) sg[7] = 1'b0;
      sl = ~(6'b000001 << i);
      if (to_b) exp_b_q.push_back({sl, sg, (i == 0)});
      else      exp_q.push_back({sl, sg, (i == 0)});
    end
    if (to_b) frame_no_b++;
    else      frame_no++;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - rel < n) @(negedge clk);
  endtask

  task automatic set_time(input logic [23:0] t);
    hour_t = t[21:20]; hour_u = t[19:16];
    min_t  = t[14:12]; min_u  = t[11:8];
    sec_t  = t[6:4];   sec_u  = t[3:0];
  endtask

  // Monitor A: pop on every new digit slot, check slot length and one-hot sel
  logic [5:0]  prev_sel = 6'h3F;
  int          last_chg = 0;
  logic [14:0] e;
  always @(negedge clk) begin
    check("sel_onehot", 32'($countones(~sel) <= 1), 32'd1);
    if (sel != prev_sel) begin
      if (sel != 6'h3F) begin
        if (prev_sel != 6'h3F) check("slot_len", cyc - last_chg, 32'd4);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_slot: got sel=%h seg=%h expected none", sel, seg);
        end else begin
          e = exp_q.pop_front();
          check("sel", sel, e[14:9]);
          check("seg", seg, e[8:1]);
          check("frame_done", frame_done, e[0]);
        end
      end
      last_chg = cyc;
      prev_sel = sel;
    end else begin
      check("fd_idle", frame_done, 32'd0);
    end
  end

  // Monitor B: T_SCAN=1, a new slot every clock
  logic [14:0] eb;
  always @(negedge clk) begin
    if (exp_b_q.size() > 0 && sel_b != 6'h3F) begin
      eb = exp_b_q.pop_front();
      check("b_sel", sel_b, eb[14:9]);
      check("b_seg", seg_b, eb[8:1]);
      check("b_frame_done", frame_done_b, eb[0]);
    end
  end

  initial begin
    rst = 1'b1;
    rst_b = 1'b1;
    set_time(24'h123456);
    repeat (3) @(negedge clk);
    check("rst_sel", sel, 32'h3F);
    check("rst_seg", seg, 32'hFF);
    check("rst_fd", frame_done, 32'd0);
    check("b_rst_sel", sel_b, 32'h3F);

    // Release both; first A digit appears 5 clocks later
    rst = 1'b0;
    rst_b = 1'b0;
    rel = cyc;
    for (int f = 0; f < 3; f++) push_frame(1'b1, 24'h123456, 6);
    for (int f = 0; f < 3; f++) push_frame(1'b0, 24'h123456, 6);
    wait_rel(4);
    check("blank_before_tick", sel, 32'h3F);
    wait_rel(5);
    check("first_digit_c5", sel, 32'h3E);

    // Change seconds while frame 2 shows min_u; takes effect in frame 3
    wait_rel(66);
    set_time(24'h123457);
    push_frame(1'b0, 24'h123457, 6);

    // Out-of-range hour units during frame 3; dash appears in frame 4
    wait_rel(90);
    set_time(24'h1C3457);
    push_frame(1'b0, 24'h1C3457, 6);
    push_frame(1'b0, 24'h1C3457, 3);

    // Reset while idx=2 of frame 5 is on display
    wait_rel(134);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel", sel, 32'h3F);
    check("midrst_seg", seg, 32'hFF);
    check("midrst_fd", frame_done, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    set_time(24'h123456);
    frame_no = 0;
    push_frame(1'b0, 24'h123456, 6);
    push_frame(1'b0, 24'h123456, 6);
    wait_rel(4);
    check("restart_blank", sel, 32'h3F);
    wait_rel(5);
    check("restart_c5", sel, 32'h3E);

    // Drain with a cycle budget
    for (int i = 0; i < 200 && (exp_q.size() > 0 || exp_b_q.size() > 0); i++)
      @(negedge clk);
    check("drain_a", exp_q.size(), 32'd0);
    check("drain_b", exp_b_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_6.md
SEG_SCAN_6 -- requirements
Module: seg_scan_6

Interface
REQ-001 The block SHALL have parameter T_SCAN, default 50_000, giving the clocks per digit slot (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter BLINK_FRAMES, default 83, giving the frames per separator toggle; it is used only under SEG_SCAN_BLINK_EN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port hour_t, input, 2 bits: BCD hours tens (0-2).
REQ-006 The block SHALL have port hour_u, input, 4 bits: BCD hours units.
REQ-007 The block SHALL have port min_t, input, 3 bits: BCD minutes tens (0-5).
REQ-008 The block SHALL have port min_u, input, 4 bits: BCD minutes units.
REQ-009 The block SHALL have port sec_t, input, 3 bits: BCD seconds tens (0-5).
REQ-010 The block SHALL have port sec_u, input, 4 bits: BCD seconds units.
REQ-011 The block SHALL have port sel, output, 6 bits: active-low digit enable; bit 0 is the leftmost digit (hour_t).
REQ-012 The block SHALL have port seg, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}, common anode.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-clock pulse at each frame start.

Function
REQ-014 The scan counter SHALL count 0..T_SCAN-1 and wrap; tick is asserted in the cycle where the count is T_SCAN-1; T_SCAN=1 gives a tick every clock.
REQ-015 The digit index SHALL be 3 bits, advance on tick, and run 0,1,2,3,4,5,0,...; values 6-7 are unreachable.
REQ-016 On the tick where the index wraps 5->0, a shadow register SHALL capture all six inputs on the same edge; display data is stable within a frame (no tearing) and input changes mid-frame appear only at the next frame.
REQ-017 Digit order SHALL be: idx0=hour_t, 1=hour_u, 2=min_t, 3=min_u, 4=sec_t, 5=sec_u, all taken from the shadow register.
REQ-018 sel and seg SHALL be registered, with exactly one clock of latency after an index or shadow change.
REQ-019 sel SHALL have exactly one bit low after the first tick and never have two bits low.
REQ-020 Decoding SHALL use the standard 0-9 active-low glyphs (0=0xC0, 1=0xF9, ..., 8=0x80, 9=0x90 with dp off); any value >9 SHALL display '-' (g only, 0xBF with dp off).
REQ-021 dp SHALL be lit (0) on idx1 and idx3 as the hh.mm.ss separator, and off (1) on all other digits.
REQ-022 frame_done SHALL pulse high for one clock, aligned with the sel update for idx0.

Reset
REQ-023 While rst is high: scan counter=0, idx=5, shadow=0, sel=6'b111111, seg=8'hFF, frame_done=0, and the blink counter and phase are cleared.
REQ-024 The first tick after reset SHALL wrap idx to 0 and load the shadow; reset asserted mid-frame SHALL abort the scan immediately, and the display SHALL be blank until that tick.

Configuration
REQ-025 With SEG_SCAN_BLINK_EN defined, a frame counter 0..BLINK_FRAMES-1 SHALL toggle a blink phase at wrap; dp on idx1/idx3 is lit only while the phase is 1 (the phase resets to 1).
REQ-026 With SEG_SCAN_BLINK_EN undefined, there SHALL be no blink counter and dp SHALL be lit steadily per REQ-021.

Structure
REQ-027 Package seg_scan_pkg SHALL hold the digit count (6), the glyph constants 0-9, the dash glyph, the blank glyph, and the separator digit positions.
REQ-028 One combinational sub-module, seg_decode (4-bit BCD in, 7-bit glyph out, dash for >9), SHALL be used; dp is muxed in the parent.

Verification
REQ-029 T_SCAN=4, inputs 12:34:56, reset released -> from cycle 5 after release, sel steps FE,FD,FB,F7,EF,DF every 4 clocks; seg follows F9,24(dp),B0,19(dp),92,82.
REQ-030 Inputs change 12:34:56->12:34:57 while idx=3 -> sec_u stays 6 (0x82) for the rest of the frame and shows 7 (0xF8) after the next frame_done.
REQ-031 hour_u=4'hC -> idx1 shows 0x3F (dash with dp lit) and no other digit is affected.
REQ-032 rst pulsed at idx=2 -> the next clock shows sel=FF, seg=FF; the scan restarts at idx0 on the first tick after release.
REQ-033 T_SCAN=1 -> index advances every clock, frame_done period is 6 clocks, and sel is always one-hot low.
REQ-034 SEG_SCAN_BLINK_EN with BLINK_FRAMES=2 -> dp on idx1/idx3 is lit for 2 frames and dark for 2 frames, repeating, while digit glyphs are unchanged.
